cvxif_multichannel_coprocessor: RTL and testbench

Parametrised CV-X-IF coprocessor that executes register–register ALU instructions on `NrChannels` independent multi-cycle channels. Results complete out of order and drain through an in-order result FIFO that honours `x_result_ready` backpressure. Attaches to the CVA6 CV-X-IF port and succeeds the single-engine example coprocessor, adding channel parallelism, result buffering and issue flow control.

---
 rtl/cvxif_mc_pkg.sv | 94 +++++++++
 rtl/cvxif_mc_result_fifo.sv | 51 +++++
 rtl/cvxif_multichannel_coprocessor.sv | 213 +++++++++++++++++++++
 tb/tb_cvxif_multichannel_coprocessor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_mc_pkg.sv
// Shared types for the multichannel CV-X-IF coprocessor: CV-X-IF bus structs,
// decode constants, ALU/channel enums and the result-FIFO entry.
package cvxif_mc_pkg;

    localparam int unsigned CvxifXlen  = 64;
    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned X_NUM_RS   = 3;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t CVA6_CFG_EMPTY = '{XLEN: 64};

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
    localparam logic [6:0] OPC_CUSTOM2 = 7'b1011011;
    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SUB = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b010;
    localparam logic [2:0] F3_AND = 3'b011;
    localparam logic [2:0] F3_OR  = 3'b100;
    localparam logic [2:0] F3_SLL = 3'b101;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_SLL, OP_ADD3
    } alu_op_e;

    typedef enum logic [1:0] {
        CH_IDLE, CH_BUSY, CH_WB
    } ch_state_e;

    typedef logic [X_ID_WIDTH-1:0] id_t;
    typedef logic [CvxifXlen-1:0]  xlen_t;

    typedef struct packed {
        id_t        id;
        logic [4:0] rd;
        xlen_t      data;
    } result_entry_t;

    typedef struct packed {
        logic [31:0]                instr;
        xlen_t [X_NUM_RS-1:0]       rs;
        logic [X_NUM_RS-1:0]        rs_valid;
        id_t                        id;
    } x_issue_req_t;

    typedef struct packed {
        logic                accept;
        logic                writeback;
        logic [X_NUM_RS-1:0] register_read;
    } x_issue_resp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        id_t   id;
        xlen_t addr;
        logic  we;
    } x_mem_req_t;

    typedef struct packed {
        id_t        id;
        xlen_t      data;
        logic [4:0] rd;
        logic       we;
        logic       exc;
        logic [5:0] exccode;
    } x_result_t;

    typedef struct packed {
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;

endpackage

// File: rtl/cvxif_mc_result_fifo.sv
// In-order result buffer: modulo-Depth pointers with a separate occupancy count.
module cvxif_mc_result_fifo #(
    parameter type         entry_t = logic,
    parameter int unsigned Depth   = 4,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW   = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  entry_t          push_data_i,
    input  logic            pop_i,
    output entry_t          head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    entry_t          mem_q [Depth];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cvxif_multichannel_coprocessor.sv
// CV-X-IF coprocessor with NrChannels multi-cycle ALU channels and an in-order result FIFO.
// Define CVXIF_MC_RS3_EN to make CUSTOM3 a legal three-source ADD3.
module cvxif_multichannel_coprocessor
    import cvxif_mc_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = CVA6_CFG_EMPTY,
    parameter int unsigned NrChannels  = 4,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned ResultDepth = 4,
    parameter int unsigned LatBits     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  cvxif_req_t  cvxif_req_i,
    output cvxif_resp_t cvxif_resp_o
);

    localparam int unsigned ShW      = $clog2(DataWidth);
    localparam int unsigned ChIdxW   = (NrChannels > 1) ? $clog2(NrChannels) : 1;
    localparam int unsigned ChCntW   = $clog2(NrChannels + 1);
    localparam int unsigned FifoCntW = $clog2(ResultDepth + 1);

    if (CVA6Cfg.XLEN != DataWidth || DataWidth != CvxifXlen) begin : g_cfg_check
        $error("DataWidth must equal XLEN");
    end

    logic [31:0]          instr;
    logic [DataWidth-1:0] rs1, rs2;
    logic                 issue_valid, legal, issue_ready, issue_fire;
    alu_op_e              op;
    logic [X_NUM_RS-1:0]  rr;
    logic [DataWidth-1:0] alu_res;
    logic [LatBits-1:0]   lat;

    ch_state_e            state_q [NrChannels];
    ch_state_e            state_d [NrChannels];
    logic [LatBits-1:0]   cnt_q   [NrChannels];
    logic [LatBits-1:0]   cnt_d   [NrChannels];
    result_entry_t        entry_q [NrChannels];
    result_entry_t        entry_d [NrChannels];

    logic                 any_idle, push, pop, fifo_empty;
    logic [ChIdxW-1:0]    alloc_idx, push_idx;
    logic [ChCntW-1:0]    nonidle_cnt;
    logic [FifoCntW-1:0]  fifo_count;
    result_entry_t        head;
    logic                 unused_c;

    assign instr       = cvxif_req_i.x_issue_req.instr;
    assign rs1         = cvxif_req_i.x_issue_req.rs[0][DataWidth-1:0];
    assign rs2         = cvxif_req_i.x_issue_req.rs[1][DataWidth-1:0];
    assign issue_valid = cvxif_req_i.x_issue_valid;
    assign lat         = rs1[LatBits-1:0];

`ifdef CVXIF_MC_RS3_EN
    logic [DataWidth-1:0] rs3;
    assign rs3      = cvxif_req_i.x_issue_req.rs[2][DataWidth-1:0];
    assign unused_c = ^{cvxif_req_i.x_issue_req.rs_valid, instr[31:15]};
`else
    assign unused_c = ^{cvxif_req_i.x_issue_req.rs_valid, instr[31:15],
                        cvxif_req_i.x_issue_req.rs[2]};
`endif

    // Decode: legality, ALU op and source registers read.
    always_comb begin
        legal = 1'b0;
        op    = OP_ADD;
        rr    = '0;
        case (instr[6:0])
            OPC_CUSTOM0: begin
                legal = 1'b1;
                rr    = 3'b011;
                case (instr[14:12])
                    F3_ADD:  op = OP_ADD;
                    F3_SUB:  op = OP_SUB;
                    F3_XOR:  op = OP_XOR;
                    F3_AND:  op = OP_AND;
                    F3_OR:   op = OP_OR;
                    F3_SLL:  op = OP_SLL;
                    default: begin
                        legal = 1'b0;
                        rr    = '0;
                    end
                endcase
            end
`ifdef CVXIF_MC_RS3_EN
            OPC_CUSTOM3: begin
                legal = 1'b1;
                op    = OP_ADD3;
                rr    = 3'b111;
            end
            OPC_CUSTOM1, OPC_CUSTOM2: legal = 1'b0;
`else
            OPC_CUSTOM1, OPC_CUSTOM2, OPC_CUSTOM3: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = rs1 + rs2;
        case (op)
            OP_SUB:  alu_res = rs1 - rs2;
            OP_XOR:  alu_res = rs1 ^ rs2;
            OP_AND:  alu_res = rs1 & rs2;
            OP_OR:   alu_res = rs1 | rs2;
            OP_SLL:  alu_res = rs1 << rs2[ShW-1:0];
`ifdef CVXIF_MC_RS3_EN
            OP_ADD3: alu_res = rs1 + rs2 + rs3;
`endif
            default: alu_res = rs1 + rs2;
        endcase
    end

    // Channel scan: lowest idle for allocation, lowest WB for the push grant.
    always_comb begin
        any_idle    = 1'b0;
        alloc_idx   = '0;
        push        = 1'b0;
        push_idx    = '0;
        nonidle_cnt = '0;
        for (int unsigned i = 0; i < NrChannels; i++) begin
            if (state_q[i] == CH_IDLE) begin
                if (!any_idle) alloc_idx = ChIdxW'(i);
                any_idle = 1'b1;
            end else begin
                nonidle_cnt = nonidle_cnt + ChCntW'(1);
            end
            if (state_q[i] == CH_WB && !push) begin
                push     = 1'b1;
                push_idx = ChIdxW'(i);
            end
        end
    end

    // Credits cover every occupied channel, so a granted push always finds room.
    assign issue_ready = any_idle && !rst_i &&
                         ((32'(nonidle_cnt) + 32'(fifo_count)) < 32'(ResultDepth));
    assign issue_fire  = issue_valid && issue_ready && legal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        for (int unsigned i = 0; i < NrChannels; i++) begin
            case (state_q[i])
                CH_IDLE: begin
                    if (issue_fire && alloc_idx == ChIdxW'(i)) begin
                        entry_d[i] = '{id:   cvxif_req_i.x_issue_req.id,
                                       rd:   instr[11:7],
                                       data: CvxifXlen'(alu_res)};
                        cnt_d[i]   = lat;
                        state_d[i] = (lat != '0) ? CH_BUSY : CH_WB;
                    end
                end
                CH_BUSY: begin
                    if (cnt_q[i] == LatBits'(1)) state_d[i] = CH_WB;
                    else                         cnt_d[i]   = cnt_q[i] - LatBits'(1);
                end
                CH_WB: begin
                    if (push && push_idx == ChIdxW'(i)) state_d[i] = CH_IDLE;
                end
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrChannels; i++) begin
                state_q[i] <= CH_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    assign pop = !fifo_empty && cvxif_req_i.x_result_ready;

    cvxif_mc_result_fifo #(
        .entry_t (result_entry_t),
        .Depth   (ResultDepth)
    ) i_result_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (entry_q[push_idx]),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        cvxif_resp_o                            = '0;
        cvxif_resp_o.x_issue_ready              = issue_ready;
        cvxif_resp_o.x_issue_resp.accept        = issue_valid && legal;
        cvxif_resp_o.x_issue_resp.writeback     = issue_valid && legal;
        cvxif_resp_o.x_issue_resp.register_read = issue_valid ? rr : '0;
        cvxif_resp_o.x_result_valid             = !fifo_empty;
        cvxif_resp_o.x_result.id                = head.id;
        cvxif_resp_o.x_result.data              = head.data;
        cvxif_resp_o.x_result.rd                = head.rd;
        cvxif_resp_o.x_result.we                = 1'b1;
    end

endmodule

// File: tb/tb_cvxif_multichannel_coprocessor.sv
// Bench for cvxif_multichannel_coprocessor: vector table plus hand-written ordering,
// backpressure, contention, illegal and reset sequences against an id-keyed scoreboard.
module tb_cvxif_multichannel_coprocessor;
    import cvxif_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    cvxif_req_t  req;
    cvxif_resp_t resp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cvxif_multichannel_coprocessor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cvxif_req_i  (req),
        .cvxif_resp_o (resp)
    );

    typedef struct { logic [3:0] id; logic [4:0] rd; logic [63:0] data; } exp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; int cyc; } obs_t;
    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] r1, r2, r3;
        logic [4:0]  exp_rsp;
        logic [63:0] exp_data;
    } vec_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    // Scoreboard: each popped result must match an outstanding expectation by id.
    always @(negedge clk) begin : monitor
        int idx;
        if (!rst && resp.x_result_valid && req.x_result_ready) begin
            idx = -1;
            obs_q.push_back('{id: resp.x_result.id, data: resp.x_result.data, cyc: cyc});
            for (int i = 0; i < exp_q.size(); i++)
                if (idx < 0 && exp_q[i].id == resp.x_result.id) idx = i;
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL sb_id: unexpected result id %0d data 0x%0h", resp.x_result.id,
                         resp.x_result.data);
            end else begin
                if ({resp.x_result.data, resp.x_result.rd, resp.x_result.we}
                    !== {exp_q[idx].data, exp_q[idx].rd, 1'b1}) begin
                    errors++;
                    $display("FAIL sb_data: id %0d got data 0x%0h rd %0d we %0b, expected 0x%0h rd %0d we 1",
                             resp.x_result.id, resp.x_result.data, resp.x_result.rd,
                             resp.x_result.we, exp_q[idx].data, exp_q[idx].rd);
                end
                exp_q.delete(idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue request, hold it until ready, report {accept,writeback,register_read}.
    task automatic do_issue(input logic [31:0] instr, input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] r3, input logic [3:0] id,
                            output logic [4:0] rsp, output int icyc);
        req.x_issue_valid          = 1'b1;
        req.x_issue_req.instr      = instr;
        req.x_issue_req.rs[0]      = r1;
        req.x_issue_req.rs[1]      = r2;
        req.x_issue_req.rs[2]      = r3;
        req.x_issue_req.rs_valid   = 3'b111;
        req.x_issue_req.id         = id;
        rsp  = '0;
        icyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (resp.x_issue_ready) begin
                rsp  = {resp.x_issue_resp.accept, resp.x_issue_resp.writeback,
                        resp.x_issue_resp.register_read};
                icyc = cyc;
                break;
            end
            step();
        end
        if (icyc < 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: id %0d never saw x_issue_ready", id);
        end
        step();
        req.x_issue_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !resp.x_result_valid) break;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    task automatic chk_obs(input string name, input int k, input logic [3:0] id,
                           input logic [63:0] data, input int ocyc);
        if (obs_q.size() > k) begin
            chk({name, "_id"},   64'(obs_q[k].id), 64'(id));
            chk({name, "_data"}, obs_q[k].data, data);
            chk({name, "_cyc"},  64'(obs_q[k].cyc), 64'(ocyc));
        end else begin
            chk({name, "_present"}, 64'(obs_q.size()), 64'(k + 1));
        end
    endtask

    vec_t       vt[12];
    logic [4:0] rsp;
    int         t, t2;
    logic [3:0] next_id;
    logic       seen;

    initial begin
        vt[0]  = '{OPC_CUSTOM0, F3_ADD, 64'd100, 64'd23, 64'd0, 5'b11011, 64'd123};
        vt[1]  = '{OPC_CUSTOM0, F3_SUB, 64'd5, 64'd7, 64'd0, 5'b11011, 64'hFFFF_FFFF_FFFF_FFFE};
        vt[2]  = '{OPC_CUSTOM0, F3_XOR, 64'hF0F0, 64'h0FF0, 64'd0, 5'b11011, 64'hFF00};
        vt[3]  = '{OPC_CUSTOM0, F3_AND, 64'hFF0F, 64'h0F0F, 64'd0, 5'b11011, 64'h0F0F};
        vt[4]  = '{OPC_CUSTOM0, F3_OR,  64'h1002, 64'h0300, 64'd0, 5'b11011, 64'h1302};
        vt[5]  = '{OPC_CUSTOM0, F3_SLL, 64'd3, 64'd4, 64'd0, 5'b11011, 64'd48};
        vt[6]  = '{OPC_CUSTOM0, F3_SLL, 64'd1, 64'd68, 64'd0, 5'b11011, 64'd16};
        vt[7]  = '{OPC_CUSTOM0, F3_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 5'b11011, 64'd1};
        vt[8]  = '{OPC_CUSTOM0, 3'b110, 64'd1, 64'd1, 64'd0, 5'b00000, 64'd0};
        vt[9]  = '{OPC_CUSTOM0, 3'b111, 64'd1, 64'd1, 64'd0, 5'b00000, 64'd0};
        vt[10] = '{OPC_CUSTOM1, F3_ADD, 64'd1, 64'd1, 64'd0, 5'b00000, 64'd0};
`ifdef CVXIF_MC_RS3_EN
        vt[11] = '{OPC_CUSTOM3, F3_ADD, 64'd1, 64'd2, 64'd3, 5'b11111, 64'd6};
`else
        vt[11] = '{OPC_CUSTOM3, F3_ADD, 64'd1, 64'd2, 64'd3, 5'b00000, 64'd0};
`endif

        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        req.x_issue_valid = 1'b0;
        @(negedge clk);
        chk("reset_issue_ready", 64'(resp.x_issue_ready), 64'd0);
        chk("reset_result_valid", 64'(resp.x_result_valid), 64'd0);
        chk("reset_issue_resp", 64'(resp.x_issue_resp), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(resp.x_issue_ready), 64'd1);
        step();

        // Vector table, back-to-back issue with mixed latencies
        req.x_result_ready = 1'b1;
        next_id = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].exp_rsp[4])
                exp_q.push_back('{id: next_id, rd: 5'(i + 1), data: vt[i].exp_data});
            do_issue(mk(vt[i].opc, vt[i].f3, 5'(i + 1)), vt[i].r1, vt[i].r2, vt[i].r3,
                     next_id, rsp, t);
            chk($sformatf("vec%0d_rsp", i), 64'(rsp), 64'(vt[i].exp_rsp));
            next_id = next_id + 4'd1;
        end
        drain();

        // Single ADD, no extra latency
        obs_q.delete();
        exp_q.push_back('{id: 4'd3, rd: 5'd5, data: 64'd11});
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd5), 64'd4, 64'd7, 64'd0, 4'd3, rsp, t);
        chk("add_rsp", 64'(rsp), 64'b11011);
        drain();
        chk_obs("add", 0, 4'd3, 64'd11, t + 2);

        // Out-of-order completion
        obs_q.delete();
        exp_q.push_back('{id: 4'd1, rd: 5'd6, data: 64'd3});
        exp_q.push_back('{id: 4'd2, rd: 5'd7, data: 64'd9});
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd6), 64'd3, 64'd0, 64'd0, 4'd1, rsp, t);
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd7), 64'd8, 64'd1, 64'd0, 4'd2, rsp, t2);
        chk("ooo_back_to_back", 64'(t2), 64'(t + 1));
        drain();
        chk_obs("ooo_first", 0, 4'd2, 64'd9, t + 3);
        chk_obs("ooo_second", 1, 4'd1, 64'd3, t + 5);

        // Two channels reach WB together: lower index wins, other waits a cycle
        obs_q.delete();
        exp_q.push_back('{id: 4'd4, rd: 5'd8, data: 64'd11});
        exp_q.push_back('{id: 4'd5, rd: 5'd9, data: 64'd5});
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd8), 64'd1, 64'd10, 64'd0, 4'd4, rsp, t);
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd9), 64'd4, 64'd1, 64'd0, 4'd5, rsp, t2);
        drain();
        chk_obs("contend_ch0", 0, 4'd4, 64'd11, t + 3);
        chk_obs("contend_ch1", 1, 4'd5, 64'd5, t + 4);

        // Backpressure: four results fill the credits
        obs_q.delete();
        req.x_result_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back('{id: 4'(6 + n), rd: 5'(10 + n), data: 64'(4 * (n + 1) + n)});
            do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'(10 + n)), 64'(4 * (n + 1)), 64'(n), 64'd0,
                     4'(6 + n), rsp, t);
        end
        @(negedge clk);
        chk("bp_ready_low", 64'(resp.x_issue_ready), 64'd0);
        step();
        step();
        @(negedge clk);
        chk("bp_ready_still_low", 64'(resp.x_issue_ready), 64'd0);
        chk("bp_valid_held", 64'(resp.x_result_valid), 64'd1);
        chk("bp_head_id", 64'(resp.x_result.id), 64'd6);
        step();
        req.x_result_ready = 1'b1;
        t = cyc;
        drain();
        for (int n = 0; n < 4; n++)
            chk_obs($sformatf("bp_drain%0d", n), n, 4'(6 + n), 64'(4 * (n + 1) + n), t + n);
        @(negedge clk);
        chk("bp_ready_restored", 64'(resp.x_issue_ready), 64'd1);
        step();

        // Illegal instruction leaves occupancy untouched
        obs_q.delete();
        do_issue(mk(OPC_CUSTOM0, 3'b110, 5'd20), 64'd1, 64'd2, 64'd0, 4'd14, rsp, t);
        chk("illegal_rsp", 64'(rsp), 64'd0);
        repeat (6) step();
        @(negedge clk);
        chk("illegal_no_result", 64'(obs_q.size()), 64'd0);
        chk("illegal_ready", 64'(resp.x_issue_ready), 64'd1);
        step();

        // Reset mid-operation: one buffered, two in flight
        obs_q.delete();
        req.x_result_ready = 1'b0;
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd21), 64'd0, 64'd1, 64'd0, 4'd10, rsp, t);
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd22), 64'd3, 64'd1, 64'd0, 4'd11, rsp, t);
        do_issue(mk(OPC_CUSTOM0, F3_ADD, 5'd23), 64'd7, 64'd1, 64'd0, 4'd12, rsp, t);
        @(negedge clk);
        chk("rst_buffered_valid", 64'(resp.x_result_valid), 64'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pulse_ready", 64'(resp.x_issue_ready), 64'd0);
        step();
        rst = 1'b0;
        req.x_result_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_valid", 64'(resp.x_result_valid), 64'd0);
        chk("rst_release_ready", 64'(resp.x_issue_ready), 64'd1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            @(negedge clk);
            if (resp.x_result_valid) seen = 1'b1;
        end
        chk("rst_no_stale_valid", 64'(seen), 64'd0);
        chk("rst_no_stale_obs", 64'(obs_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
